// File: rtl/v_issue_queue_if.sv
// Bundle of dispatch-side, issue-side, writeback and status signals of the
// vector issue queue. The dispatching core / bench uses the master modport,
// the queue uses the slave modport.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both 1. valid never depends on ready. instr_ready
// and issue_valid depend only on registered queue state, never on the
// same-cycle inputs.
interface v_issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int NUM_VREGS = 32,
    parameter int CNT_W     = $clog2(DEPTH) + 1
);
    logic                 instr_valid;
    logic [31:0]          instr;
    logic                 instr_ready;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [31:0]          issue_instr;
    logic [5:0]           issue_unit;
    logic                 wb_valid;
    logic [4:0]           wb_vd;
    logic                 flush;
    logic                 illegal;
    logic [CNT_W-1:0]     count;
    logic [NUM_VREGS-1:0] busy_vregs;

    modport master (
        output instr_valid, instr, issue_ready, wb_valid, wb_vd, flush,
        input  instr_ready, issue_valid, issue_instr, issue_unit, illegal,
               count, busy_vregs
    );

    modport slave (
        input  instr_valid, instr, issue_ready, wb_valid, wb_vd, flush,
        output instr_ready, issue_valid, issue_instr, issue_unit, illegal,
               count, busy_vregs
    );
endinterface

// File: rtl/v_issue_queue.sv
// In-order vector instruction issue queue. Buffers vector instructions in a
// DEPTH-entry FIFO, classifies the head by target unit, and issues it only
// when the vreg scoreboard shows no RAW/WAW hazard. vconfig instructions act
// as a barrier and wait for an empty scoreboard.
module v_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_VREGS = 32,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    v_issue_queue_if.slave q
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OP_V  = 7'b1010111;
    localparam logic [6:0] OP_LD = 7'b0000111;
    localparam logic [6:0] OP_ST = 7'b0100111;

    // State
    logic [31:0]          mem_q [DEPTH];
    logic [31:0]          mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_VREGS-1:0] busy_q, busy_d;
    logic                 illegal_q, illegal_d;

    // Head decode
    logic [31:0]          head;
    logic                 head_present;
    logic                 is_opv, is_ld, is_st;
    logic [2:0]           f3;
    logic [5:0]           f6;
    logic                 u_cfg, u_lsu, u_sldu, u_red, u_mul, u_alu;
    logic [5:0]           unit;
    logic                 classified;
    logic [NUM_VREGS-1:0] check_mask;
    logic                 hazard;
    logic                 can_issue;
    logic                 writes_vd;

    // Handshake / update strobes
    logic                 enq_fire;
    logic                 enq_legal;
    logic                 enq_store;
    logic                 issue_fire;
    logic                 drop;
    logic                 pop;
    logic [NUM_VREGS-1:0] set_mask;
    logic [NUM_VREGS-1:0] clr_mask;

    function automatic logic [NUM_VREGS-1:0] vreg_bit(input logic [4:0] r);
        logic [NUM_VREGS-1:0] m;
        for (int i = 0; i < NUM_VREGS; i++) begin
            m[i] = (r == 5'(i));
        end
        return m;
    endfunction

    // funct6 codes of the plain integer ops handled by the VALU
    function automatic logic is_alu_f6(input logic [5:0] f);
        case (f)
            6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b001011,
            6'b100101, 6'b101000, 6'b101001, 6'b000101, 6'b000111:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // Classify the head instruction and evaluate its hazards
    always_comb begin
        head         = mem_q[rd_ptr_q];
        head_present = (count_q != '0);
        f3           = head[14:12];
        f6           = head[31:26];
        is_opv       = (head[6:0] == OP_V);
        is_ld        = (head[6:0] == OP_LD);
        is_st        = (head[6:0] == OP_ST);

        u_cfg  = is_opv && (f3 == 3'b111);
        u_mul  = is_opv && (f6 == 6'b100101) && (f3 == 3'b010 || f3 == 3'b110);
        u_red  = is_opv && (f6 == 6'b000000 || f6 == 6'b000111) && (f3 == 3'b010);
        u_sldu = is_opv && (
                   ((f6 == 6'b001110 || f6 == 6'b001111) &&
                    (f3 == 3'b100 || f3 == 3'b011 || f3 == 3'b110)) ||
                   ((f6 == 6'b010111 || f6 == 6'b010000) &&
                    (f3 == 3'b010 || f3 == 3'b110)));
        u_alu  = is_opv && is_alu_f6(f6) &&
                 (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
        // For loads/stores f3 holds the element width and [27:26] is mop
        u_lsu  = (is_ld || is_st) &&
                 (head[27:26] == 2'b00 || head[27:26] == 2'b10) &&
                 (f3 == 3'b000 || f3 == 3'b101 || f3 == 3'b110);

        unit       = {u_cfg, u_lsu, u_sldu, u_red, u_mul, u_alu};
        classified = (unit != '0);
        writes_vd  = u_alu || u_mul || u_red || u_sldu || (u_lsu && is_ld);

        check_mask = '0;
        if (is_opv) begin
            check_mask = check_mask | vreg_bit(head[24:20]);
        end
        if (is_opv && (f3 == 3'b000 || f3 == 3'b010)) begin
            check_mask = check_mask | vreg_bit(head[19:15]);
        end
        // [11:7] is vs3 for stores and vd for everything except vconfig
        if (!u_cfg) begin
            check_mask = check_mask | vreg_bit(head[11:7]);
        end

        if (u_cfg) begin
            hazard = (busy_q != '0);
        end else begin
            hazard = ((busy_q & check_mask) != '0);
        end

        can_issue = head_present && classified && !hazard;
    end

    // Handshake strobes and next-state for pointers, storage and scoreboard
    always_comb begin
        enq_fire   = q.instr_valid && (count_q != CNT_W'(DEPTH));
        enq_legal  = (q.instr[6:0] == OP_V) || (q.instr[6:0] == OP_LD) ||
                     (q.instr[6:0] == OP_ST);
        enq_store  = enq_fire && enq_legal && !q.flush;
        issue_fire = can_issue && q.issue_ready && !q.flush;
        drop       = head_present && !classified && !q.flush;
        pop        = issue_fire || drop;

        set_mask = (issue_fire && writes_vd) ? vreg_bit(head[11:7]) : '0;
        clr_mask = q.wb_valid ? vreg_bit(q.wb_vd) : '0;
        // A set outranks a clear of the same bit
        busy_d   = (busy_q & ~clr_mask) | set_mask;

        illegal_d = !q.flush && ((enq_fire && !enq_legal) || drop);

        mem_d = mem_q;
        if (enq_store) begin
            mem_d[wr_ptr_q] = q.instr;
        end

        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = enq_store ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_d  = count_q + CNT_W'(enq_store) - CNT_W'(pop);
        end
    end

    // Register update; reset clears control state but not the storage array
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
        mem_q <= mem_d;
    end

    assign q.instr_ready = (count_q != CNT_W'(DEPTH));
    assign q.issue_valid = can_issue;
    assign q.issue_instr = head;
    assign q.issue_unit  = unit;
    assign q.illegal     = illegal_q;
    assign q.count       = count_q;
    assign q.busy_vregs  = busy_q;
endmodule

// File: tb/tb_v_issue_queue.sv
// Directed bench for v_issue_queue: a table of per-cycle vectors for the
// basic issue/hazard/illegal paths, then hand-written sequences for the
// full-queue, flush, reset and vconfig barrier cases.
module tb_v_issue_queue;
    localparam int DEPTH = 4;
    localparam int NV    = 32;
    localparam int CW    = 3;

    localparam logic [6:0] OPV = 7'b1010111;
    localparam logic [6:0] OLD = 7'b0000111;
    localparam logic [6:0] OST = 7'b0100111;

    localparam logic [5:0] U_ALU = 6'b000001;
    localparam logic [5:0] U_MUL = 6'b000010;
    localparam logic [5:0] U_LSU = 6'b010000;
    localparam logic [5:0] U_CFG = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    v_issue_queue_if #(.DEPTH(DEPTH), .NUM_VREGS(NV), .CNT_W(CW)) bus ();

    v_issue_queue #(.DEPTH(DEPTH), .NUM_VREGS(NV), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] f6, input logic [4:0] vs2,
                                        input logic [4:0] vs1, input logic [2:0] f3,
                                        input logic [4:0] vd, input logic [6:0] op);
        return {f6, 1'b1, vs2, vs1, f3, vd, op};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy,
                         input logic wb, input logic [4:0] wbvd, input logic fl);
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.issue_ready = rdy;
        bus.wb_valid    = wb;
        bus.wb_vd       = wbvd;
        bus.flush       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        rdy;
        logic        wb;
        logic [4:0]  wbvd;
        logic        e_iv;
        logic [5:0]  e_unit;
        logic [2:0]  e_cnt;
        logic [31:0] e_busy;
        logic        e_ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic rdy,
                                input logic wb, input logic [4:0] wbvd, input logic e_iv,
                                input logic [5:0] e_unit, input logic [2:0] e_cnt,
                                input logic [31:0] e_busy, input logic e_ill);
        vec_t r;
        r.v = v; r.ins = ins; r.rdy = rdy; r.wb = wb; r.wbvd = wbvd;
        r.e_iv = e_iv; r.e_unit = e_unit; r.e_cnt = e_cnt;
        r.e_busy = e_busy; r.e_ill = e_ill;
        return r;
    endfunction

    logic [31:0] i_a, i_b, i_m, i_c, i_ill, i_ld, i_st, i_u, i_v2, i_cfg, i_x;
    logic [31:0] i_f [5];

    initial begin
        i_a   = enc(6'b000000, 5'd1, 5'd2, 3'b000, 5'd3, OPV);    // vadd.vv v3,v1,v2
        i_b   = enc(6'b000000, 5'd5, 5'd6, 3'b000, 5'd4, OPV);    // vadd.vv v4,v5,v6
        i_m   = enc(6'b100101, 5'd1, 5'd2, 3'b010, 5'd3, OPV);    // vmul.vv v3,v1,v2
        i_c   = enc(6'b000000, 5'd3, 5'd2, 3'b000, 5'd7, OPV);    // vadd.vv v7,v3,v2
        i_ill = 32'h002081b3;                                     // add x3,x1,x2
        i_ld  = enc(6'b000000, 5'd0, 5'd5, 3'b110, 5'd8, OLD);    // vle32.v v8,(x5)
        i_st  = enc(6'b000000, 5'd0, 5'd5, 3'b110, 5'd9, OST);    // vse32.v v9,(x5)
        i_u   = enc(6'b000000, 5'd1, 5'd2, 3'b001, 5'd5, OPV);    // OPFVV: no unit
        i_v2  = enc(6'b000000, 5'd0, 5'd1, 3'b000, 5'd2, OPV);    // vadd.vv v2,v0,v1
        i_cfg = {1'b0, 11'd0, 5'd10, 3'b111, 5'd5, OPV};          // vsetvli x5,x10,e8
        for (int k = 0; k < 5; k++) begin
            i_f[k] = enc(6'b000000, 5'd20, 5'd21, 3'b000, 5'(10 + k), OPV);
        end

        //             v  ins    rdy wb vd   iv unit  cnt busy       ill
        tbl.push_back(mk(1, i_a,   0, 0, 0,  0, 6'h0, 0, 32'h0,     0));
        tbl.push_back(mk(1, i_b,   1, 0, 0,  1, U_ALU, 1, 32'h0,    0));
        tbl.push_back(mk(0, 0,     1, 0, 0,  1, U_ALU, 1, 32'h8,    0));
        tbl.push_back(mk(0, 0,     0, 1, 3,  0, 6'h0, 0, 32'h18,    0));
        tbl.push_back(mk(0, 0,     0, 1, 4,  0, 6'h0, 0, 32'h10,    0));
        tbl.push_back(mk(1, i_m,   1, 0, 0,  0, 6'h0, 0, 32'h0,     0));
        tbl.push_back(mk(1, i_c,   1, 0, 0,  1, U_MUL, 1, 32'h0,    0));
        tbl.push_back(mk(0, 0,     1, 0, 0,  0, 6'h0, 1, 32'h8,     0));
        tbl.push_back(mk(0, 0,     1, 1, 3,  0, 6'h0, 1, 32'h8,     0));
        tbl.push_back(mk(0, 0,     1, 0, 0,  1, U_ALU, 1, 32'h0,    0));
        tbl.push_back(mk(0, 0,     0, 1, 7,  0, 6'h0, 0, 32'h80,    0));
        tbl.push_back(mk(1, i_ill, 0, 0, 0,  0, 6'h0, 0, 32'h0,     0));
        tbl.push_back(mk(0, 0,     0, 0, 0,  0, 6'h0, 0, 32'h0,     1));
        tbl.push_back(mk(1, i_ld,  0, 0, 0,  0, 6'h0, 0, 32'h0,     0));
        tbl.push_back(mk(0, 0,     1, 0, 0,  1, U_LSU, 1, 32'h0,    0));
        tbl.push_back(mk(1, i_st,  1, 1, 8,  0, 6'h0, 0, 32'h100,   0));
        tbl.push_back(mk(0, 0,     1, 0, 0,  1, U_LSU, 1, 32'h0,    0));
        tbl.push_back(mk(1, i_u,   0, 0, 0,  0, 6'h0, 0, 32'h0,     0));
        tbl.push_back(mk(0, 0,     1, 0, 0,  0, 6'h0, 1, 32'h0,     0));
        tbl.push_back(mk(0, 0,     0, 0, 0,  0, 6'h0, 0, 32'h0,     1));
        tbl.push_back(mk(0, 0,     0, 0, 0,  0, 6'h0, 0, 32'h0,     0));

        // Instructions the table expects to issue, in order
        exp_q.push_back(i_a);
        exp_q.push_back(i_b);
        exp_q.push_back(i_m);
        exp_q.push_back(i_c);
        exp_q.push_back(i_ld);
        exp_q.push_back(i_st);
    end

    // ---------------- stimulus and checking ----------------
    initial begin
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_busy", bus.busy_vregs, 32'h0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);

        // Table-driven section: outputs reflect state before this row's edge
        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].v, tbl[r].ins, tbl[r].rdy, tbl[r].wb, tbl[r].wbvd, 0);
            #1;
            check($sformatf("row%0d_issue_valid", r), 32'(bus.issue_valid), 32'(tbl[r].e_iv));
            check($sformatf("row%0d_count", r), 32'(bus.count), 32'(tbl[r].e_cnt));
            check($sformatf("row%0d_instr_ready", r), 32'(bus.instr_ready),
                  32'(tbl[r].e_cnt != 3'(DEPTH)));
            check($sformatf("row%0d_busy", r), bus.busy_vregs, tbl[r].e_busy);
            check($sformatf("row%0d_illegal", r), 32'(bus.illegal), 32'(tbl[r].e_ill));
            if (tbl[r].e_iv) begin
                check($sformatf("row%0d_unit", r), 32'(bus.issue_unit), 32'(tbl[r].e_unit));
            end
            if (tbl[r].e_iv && tbl[r].rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL row%0d_sb: act=issue req=empty_queue", r);
                end else begin
                    check($sformatf("row%0d_issue_instr", r), bus.issue_instr, exp_q.pop_front());
                end
            end
            step();
        end
        check("table_sb_drained", 32'(exp_q.size()), 32'd0);

        // Fill the queue with the issue side stalled
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, i_f[k], 0, 0, 5'd0, 0);
            #1;
            check($sformatf("fill%0d_count", k), 32'(bus.count), 32'(k));
            check($sformatf("fill%0d_instr_ready", k), 32'(bus.instr_ready), 32'd1);
            step();
        end
        // Fifth offer while full
        drive(1, i_f[4], 0, 0, 5'd0, 0);
        #1;
        check("full_count", 32'(bus.count), 32'd4);
        check("full_instr_ready", 32'(bus.instr_ready), 32'd0);
        check("full_issue_valid", 32'(bus.issue_valid), 32'd1);
        step();
        // One issue
        drive(0, 32'h0, 1, 0, 5'd0, 0);
        #1;
        check("full_no_accept_count", 32'(bus.count), 32'd4);
        check("full_head_instr", bus.issue_instr, i_f[0]);
        step();
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        #1;
        check("after_pop_count", 32'(bus.count), 32'd3);
        check("after_pop_instr_ready", 32'(bus.instr_ready), 32'd1);
        check("after_pop_busy", bus.busy_vregs, 32'h400);

        // Flush with 3 queued, a simultaneous enqueue and a ready issue side
        drive(1, i_f[4], 1, 0, 5'd0, 1);
        step();
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        #1;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("flush_busy_kept", bus.busy_vregs, 32'h400);
        check("flush_instr_ready", 32'(bus.instr_ready), 32'd1);
        step();

        // Reset mid-operation clears the scoreboard
        rst = 1'b1;
        drive(1, i_a, 0, 0, 5'd0, 0);
        step();
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        #1;
        check("rst2_busy", bus.busy_vregs, 32'h0);
        check("rst2_count", 32'(bus.count), 32'd0);
        check("rst2_instr_ready", 32'(bus.instr_ready), 32'd1);

        // vconfig barrier behind a busy v2
        drive(1, i_v2, 1, 0, 5'd0, 0);
        step();
        drive(1, i_cfg, 1, 0, 5'd0, 0);
        #1;
        check("cfg_pre_issue_valid", 32'(bus.issue_valid), 32'd1);
        check("cfg_pre_unit", 32'(bus.issue_unit), 32'(U_ALU));
        step();
        drive(0, 32'h0, 1, 1, 5'd9, 0);   // release of an already-clear reg
        #1;
        check("cfg_hold0_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("cfg_hold0_busy", bus.busy_vregs, 32'h4);
        check("cfg_hold0_count", 32'(bus.count), 32'd1);
        step();
        drive(0, 32'h0, 1, 1, 5'd2, 0);
        #1;
        check("cfg_hold1_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("cfg_hold1_busy", bus.busy_vregs, 32'h4);
        step();
        drive(0, 32'h0, 1, 0, 5'd0, 0);
        #1;
        check("cfg_issue_valid", 32'(bus.issue_valid), 32'd1);
        check("cfg_unit", 32'(bus.issue_unit), 32'(U_CFG));
        check("cfg_instr", bus.issue_instr, i_cfg);
        check("cfg_busy", bus.busy_vregs, 32'h0);
        step();
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        #1;
        check("cfg_post_count", 32'(bus.count), 32'd0);
        check("cfg_post_busy", bus.busy_vregs, 32'h0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/v_issue_queue.md
Name: v_issue_queue

Overview:
- Parametrised successor to the combinational vector decoder.
- Buffers incoming 32-bit vector instructions in a DEPTH-entry in-order FIFO and classifies the head instruction by target unit.
- Tracks in-flight vector destination registers in a scoreboard and issues the head only when it has no RAW/WAW hazard.
- Sits between the scalar core's vector dispatch and the per-unit decoders (VALU, MUL, RED, SLDU, LSU, vconfig).

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- NUM_VREGS, 32, number of architectural vector registers tracked by the scoreboard.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Synchronous active-high reset.
- instr_valid  in  1  An instruction is offered this cycle.
- instr  in  32  Offered instruction.
- instr_ready  out  1  Queue can accept; equals (count != DEPTH).
- issue_valid  out  1  Head is issuable this cycle.
- issue_ready  in  1  Downstream accepts the head.
- issue_instr  out  32  Head instruction.
- issue_unit  out  6  One-hot target {CFG,LSU,SLDU,RED,MUL,ALU} for bits [5:0].
- wb_valid  in  1  A unit has completed a write to a vector register.
- wb_vd  in  5  Register being released.
- flush  in  1  Discard all queued entries.
- illegal  out  1  One-cycle pulse: an accepted instruction was not vector or not decodable.
- count  out  CNT_W  Current occupancy.
- busy_vregs  out  NUM_VREGS  Scoreboard contents.

Behaviour:
- **Clock and reset:** one clock, clk; reset is synchronous and active-high (rst).
- **Reset values:** the following are 0: pointers, count, scoreboard, illegal, issue_valid. instr_ready is 1.
- **Enqueue** fires when instr_valid && instr_ready.
  - Opcode must be 1010111 (OP-V), 0000111 (vector load) or 0100111 (vector store).
  - Any other opcode is consumed without being stored, and illegal pulses on the next cycle.
- **Instruction classification** (head, combinational):
  - OP-V with funct3=111 -> CFG.
  - funct6 100101 with OPMVV/OPMVX (010/110) -> MUL.
  - funct6 000000/000111 with OPMVV -> RED.
  - The following -> SLDU:
    - funct6 001110/001111 with OPIVX/OPIVI (100/011).
    - funct6 001110/001111 with OPMVX.
    - funct6 010111/010000 with OPMVV/OPMVX.
  - ALU funct6 codes (vadd, vsub, vand, vor, vxor, vsll, vsrl, vsra, vmin, vmax) with OPIVV/OPIVX/OPIVI -> ALU.
  - Vector load or store with mop 00 or 10 and width 000/101/110 -> LSU.
  - Unclassifiable head: the entry is dropped without issue (pops in one cycle, issue_valid stays 0) and illegal pulses.
- **Hazard check** uses registered busy_vregs only; there is no wb bypass.
  - Sources checked:
    - vs2 = instr[24:20] for OP-V.
    - vs1 = instr[19:15] when funct3 is OPIVV or OPMVV.
    - vs3 = instr[11:7] for stores.
  - Destination checked: vd = instr[11:7] for every non-store, non-CFG instruction.
  - Any checked bit set -> issue_valid = 0.
  - CFG issues only when busy_vregs == 0.
- **Issue** fires when issue_valid && issue_ready:
  - Pop the head.
  - Set busy_vregs[vd] for unit types ALU/MUL/RED/SLDU and for loads.
- **Writeback:** wb_valid clears busy_vregs[wb_vd].
  - Same-cycle set and clear of the same bit cannot occur, because issue requires the bit to be clear.
  - If it would occur, the set wins.
  - wb_valid on an already-clear bit has no effect.
- **Latency:** an instruction accepted in cycle N is visible at the head and can issue in cycle N+1 at the earliest. Throughput is 1 per cycle.
- **Occupancy:** simultaneous enqueue and issue at full is not permitted (instr_ready=0 when full). At any other count, simultaneous enqueue and issue leaves count unchanged.
- **Pointers:** pointers wrap modulo DEPTH.
- **Empty queue:** issue_valid = 0; issue_instr holds the stale entry and is don't-care.
- **Flush:**
  - Next-edge effect: pointers and count go to 0. The scoreboard is kept.
  - Flush overrides same-cycle enqueue and issue; neither takes effect.
  - instr_ready stays per count.
- **rst** mid-operation overrides flush, wb and enqueue.

Test Plan:
1. **Back-to-back issue:** enqueue vadd.vv v3,v1,v2 then vadd.vv v4,v5,v6 with issue_ready=1 -> issue in cycles 1 and 2, issue_unit=000001, and busy_vregs bits 3 and 4 set.
2. **RAW stall:** vmul.vv v3,v1,v2, then vadd.vv v7,v3,v2 -> second instruction stalls (issue_valid=0) until wb_valid with wb_vd=3, then issues in the following cycle.
3. **Full queue:** fill DEPTH=4 entries with issue_ready=0 -> count=4, instr_ready=0, and a fifth offer is not accepted. One issue -> instr_ready=1 in the next cycle.
4. **CFG barrier:** vsetvli with v2 busy -> held until busy_vregs==0, then issues with issue_unit=100000.
5. **Illegal:** offer opcode 0110011 -> count unchanged and illegal=1 for exactly one cycle.
6. **Flush:** flush with 3 entries queued and a simultaneous enqueue -> count=0 and issue_valid=0 next cycle, busy_vregs unchanged. rst after that -> busy_vregs=0.
